pos_logic_pipe: RTL



---
 rtl/pos_logic_pipe_if.sv | 58 +++++
 rtl/pos_logic_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pos_logic_pipe_if.sv
// Interface bundling the operand/result handshake of pos_logic_pipe.
// Optional POPCNT signal present only when POS_LOGIC_POPCNT_EN is defined.
//
// Handshake (both directions): a beat transfers on a rising clock edge
// when valid && ready are both high in the cycle before that edge.
// - The producer holds valid and its payload until the beat transfers.
// - valid never depends on ready.
// - ready may depend on downstream ready, but never on valid.
`timescale 1ns/100ps

interface pos_logic_pipe_if #(
  parameter int WIDTH = 16
);
`ifdef POS_LOGIC_POPCNT_EN
  localparam int PCW = $clog2(WIDTH + 1);
`endif

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             parity;
`ifdef POS_LOGIC_POPCNT_EN
  logic [PCW-1:0]   popcnt;
`endif

`ifdef POS_LOGIC_POPCNT_EN
  // Producer/consumer side: supplies operands and accepts results.
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, zero, parity, popcnt
  );

  // Logic unit side.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, zero, parity, popcnt
  );
`else
  // Producer/consumer side: supplies operands and accepts results.
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, zero, parity
  );

  // Logic unit side.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, zero, parity
  );
`endif

endinterface

// File: rtl/pos_logic_pipe.sv
// pos_logic_pipe: pipelined bitwise logic unit with ZERO/PARITY flags.
// Stage 1 evaluates the operation and flags; stages 2..STAGES only delay
// result+flags+valid. Each stage has its own backpressure so bubbles
// collapse while the output is stalled.
// Optional feature macro: POS_LOGIC_POPCNT_EN adds a POPCNT output that
// travels with the beat.
`timescale 1ns/100ps

module pos_logic_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  pos_logic_pipe_if.slave bus
);

  // Reject illegal configurations at elaboration time.
  generate
    if (WIDTH < 1 || WIDTH > 64 || STAGES < 1 || STAGES > 4) begin : g_bad_params
      $error("pos_logic_pipe: WIDTH must be 1..64 and STAGES 1..4");
    end
  endgenerate

`ifdef POS_LOGIC_POPCNT_EN
  localparam int PCW = $clog2(WIDTH + 1);
`endif

  // Operation codes.
  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_XNOR  = 3'b011;
  localparam logic [2:0] OP_NAND  = 3'b100;
  localparam logic [2:0] OP_NOR   = 3'b101;
  localparam logic [2:0] OP_NOTA  = 3'b110;
  localparam logic [2:0] OP_ANDNB = 3'b111;

  // Stage-1 combinational result.
  logic [WIDTH-1:0] res_d;
  logic             zero_d;
  logic             parity_d;
`ifdef POS_LOGIC_POPCNT_EN
  logic [PCW-1:0]   popcnt_d;
`endif

  // Per-stage registers; index 1 is the compute stage, STAGES drives the outputs.
  logic [STAGES:1]  vld_q;
  logic [WIDTH-1:0] res_q    [1:STAGES];
  logic             zero_q   [1:STAGES];
  logic             parity_q [1:STAGES];
`ifdef POS_LOGIC_POPCNT_EN
  logic [PCW-1:0]   popcnt_q [1:STAGES];
`endif

  // rdy[k]: stage k may load this cycle (it is empty or its beat moves on).
  logic [STAGES:1]  rdy;
  logic             rdy_chain;

  // Evaluate the selected bitwise operation and its flags.
  always_comb begin
    res_d = '0;
    case (bus.op)
      OP_AND:   res_d = bus.a & bus.b;
      OP_OR:    res_d = bus.a | bus.b;
      OP_XOR:   res_d = bus.a ^ bus.b;
      OP_XNOR:  res_d = ~(bus.a ^ bus.b);
      OP_NAND:  res_d = ~(bus.a & bus.b);
      OP_NOR:   res_d = ~(bus.a | bus.b);
      OP_NOTA:  res_d = ~bus.a;
      OP_ANDNB: res_d = bus.a & ~bus.b;
      default:  res_d = '0;
    endcase
    zero_d   = ~|res_d;
    parity_d = ^res_d;
  end

`ifdef POS_LOGIC_POPCNT_EN
  // Count the ones in the stage-1 result.
  always_comb begin
    popcnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt_d = popcnt_d + PCW'(res_d[i]);
    end
  end
`endif

  // Backpressure chain, walked from the output back towards the input:
  // a stage is ready if it or any stage after it is empty, or the
  // consumer takes the last beat. No dependence on in_valid.
  always_comb begin
    rdy       = '0;
    rdy_chain = bus.out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      rdy_chain = rdy_chain | ~vld_q[k];
      rdy[k]    = rdy_chain;
    end
  end

  // Stage registers: load from the previous stage whenever ready; payload
  // only updates when a valid beat arrives, stale data is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        res_q[k]    <= '0;
        zero_q[k]   <= 1'b0;
        parity_q[k] <= 1'b0;
`ifdef POS_LOGIC_POPCNT_EN
        popcnt_q[k] <= '0;
`endif
      end
    end else begin
      if (rdy[1]) begin
        vld_q[1] <= bus.in_valid;
        if (bus.in_valid) begin
          res_q[1]    <= res_d;
          zero_q[1]   <= zero_d;
          parity_q[1] <= parity_d;
`ifdef POS_LOGIC_POPCNT_EN
          popcnt_q[1] <= popcnt_d;
`endif
        end
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            res_q[k]    <= res_q[k-1];
            zero_q[k]   <= zero_q[k-1];
            parity_q[k] <= parity_q[k-1];
`ifdef POS_LOGIC_POPCNT_EN
            popcnt_q[k] <= popcnt_q[k-1];
`endif
          end
        end
      end
    end
  end

  assign bus.in_ready  = rdy[1];
  assign bus.out_valid = vld_q[STAGES];
  assign bus.out       = res_q[STAGES];
  assign bus.zero      = zero_q[STAGES];
  assign bus.parity    = parity_q[STAGES];
`ifdef POS_LOGIC_POPCNT_EN
  assign bus.popcnt    = popcnt_q[STAGES];
`endif

endmodule
